alu_exec: RTL and testbench

- Execute-stage ALU, directly downstream of alu_control.
- Consumes the 4-bit alu_ctrl code plus two operands and produces a registered result with a zero flag for branch resolution.
- Logical, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, through a small FSM.
- Valid/ready handshakes on both sides, so a stall on the result side back-pressures the decode stage.

---
 rtl/alu_exec.sv | 189 ++++++++++++++++++
 tb/tb_alu_exec.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU sitting directly behind alu_control.
//
// Logical, arithmetic, compare and illegal codes finish in one cycle. A shift
// by a nonzero amount is done one bit per cycle in the SHIFT state. Results
// land in a single output register that has a valid/ready handshake, so a
// stalled consumer back-pressures the decode stage through in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operation request valid
//   in_ready   combinational: a request can be accepted this cycle
//   alu_ctrl   operation code (CTRL_W bits)
//   op_a       operand A (rs1)
//   op_b       operand B (rs2 or immediate); shifts use op_b[SHW-1:0]
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer takes the result at this edge
//   result     registered result
//   zero       registered (result == 0)
//   illegal    registered: the accepted alu_ctrl was unsupported
//
// States:
//   state | meaning
//   IDLE  | can accept a request when the output slot is free or draining
//   SHIFT | iterative shift running; cnt_q = single-bit steps still to do

module alu_exec #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4,
    parameter int SHW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero,
    output logic              illegal
);

    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1001);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [CTRL_W-1:0] kind_q, kind_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic              accept;
    logic              is_shift;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ill;
    logic [XLEN-1:0]   step;

    assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign shamt     = op_b[SHW-1:0];
    assign is_shift  = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Single-cycle datapath. Shift codes only reach the output through this
    // path when the shift amount is zero, so they simply pass op_a.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_res = op_a;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: alu_ill = 1'b1;
        endcase
    end

    // One-bit shift step for the iterative path.
    always_comb begin
        step = work_q;
        case (kind_q)
            OP_SLL:  step = {work_q[XLEN-2:0], 1'b0};
            OP_SRL:  step = {1'b0, work_q[XLEN-1:1]};
            OP_SRA:  step = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: step = work_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        kind_d      = kind_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;

        // Drain first; a result written below in the same cycle overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = S_SHIFT;
                        work_d  = op_a;
                        cnt_d   = shamt;
                        kind_d  = alu_ctrl;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        illegal_d   = alu_ill;
                    end
                end
            end
            S_SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - SHW'(1);
                // The slot is guaranteed empty here: accept required it to be
                // free or draining, and nothing else writes it during SHIFT.
                if (cnt_q == SHW'(1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = step;
                    zero_d      = (step == '0);
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            kind_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            kind_q      <= kind_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: directed scenarios plus randomized operations,
// all checked against a reference model built from plain arithmetic.

module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_exec #(.XLEN(32), .CTRL_W(4), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: what the op means, plus the cycle count it is allowed.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int n;
        n   = int'(b % 32);
        r   = 32'h0;
        ill = 1'b0;
        lat = 1;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a ^ b;
            4'd6: r = a - b;
            4'd4: begin r = a << n; lat = 1 + n; end
            4'd5: begin r = a >> n; lat = 1 + n; end
            4'd7: begin r = $unsigned($signed(a) >>> n); lat = 1 + n; end
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eill;
        int          elat;
        int          lat;
        int          waits;
        int          busy_bad;
        int          stall;
        string       t;
        model(c, a, b, er, eill, elat);
        t = $sformatf("op%0d a=%08h b=%08h", c, a, b);
        @(negedge clk);
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk({t, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must ignore them.
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        @(negedge clk);
        lat = 1;
        busy_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_bad++;
            @(negedge clk);
            lat++;
        end
        chk({t, " latency"}, 32'(lat), 32'(elat));
        chk({t, " result"}, result, er);
        chk({t, " zero"}, {31'b0, zero}, {31'b0, (er == 32'h0)});
        chk({t, " illegal"}, {31'b0, illegal}, {31'b0, eill});
        chk({t, " busy_ready"}, 32'(busy_bad), 32'd0);
        stall = $urandom_range(0, 2);
        if (stall > 0) begin
            out_ready = 1'b0;
            repeat (stall) @(negedge clk);
            chk({t, " held"}, result, er);
            chk({t, " held_valid"}, {31'b0, out_valid}, 32'd1);
            out_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk({t, " drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin : main
        logic [3:0]  bc [4];
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        logic [31:0] er;
        logic        eill;
        int          elat;
        int          seen;

        rst = 1'b1; in_valid = 1'b1; alu_ctrl = 4'd2; op_a = 32'd1; op_b = 32'd2; out_ready = 1'b1;

        // Reset with a pending request
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst zero", {31'b0, zero}, 32'd0);
        chk("rst illegal", {31'b0, illegal}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops
        bc[0] = 4'd2; ba[0] = 32'd7;          bb[0] = 32'd5;
        bc[1] = 4'd6; ba[1] = 32'd5;          bb[1] = 32'd5;
        bc[2] = 4'd8; ba[2] = 32'hFFFF_FFFF;  bb[2] = 32'd1;
        bc[3] = 4'd9; ba[3] = 32'hFFFF_FFFF;  bb[3] = 32'd1;
        @(negedge clk);
        alu_ctrl = bc[0]; op_a = ba[0]; op_b = bb[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) begin
                alu_ctrl = bc[i+1]; op_a = ba[i+1]; op_b = bb[i+1];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            model(bc[i], ba[i], bb[i], er, eill, elat);
            chk($sformatf("b2b%0d valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d result", i), result, er);
            chk($sformatf("b2b%0d zero", i), {31'b0, zero}, {31'b0, (er == 32'h0)});
        end
        @(negedge clk);
        chk("b2b drained", {31'b0, out_valid}, 32'd0);

        // Directed shifts
        run_op(4'd7, 32'h8000_0000, 32'd4);
        run_op(4'd4, 32'd1, 32'd31);
        run_op(4'd5, 32'h1234_5678, 32'h20);

        // Back-pressure and replace-on-drain
        @(negedge clk);
        out_ready = 1'b0; alu_ctrl = 4'd0; op_a = 32'hF0F0; op_b = 32'hFF00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_ctrl = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d result", i), result, 32'h0000_F000);
            chk($sformatf("bp%0d in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp or valid", {31'b0, out_valid}, 32'd1);
        chk("bp or result", result, 32'h0000_FFF0);
        @(negedge clk);
        chk("bp drained", {31'b0, out_valid}, 32'd0);

        // Reset in the middle of a long shift
        @(negedge clk);
        alu_ctrl = 4'd4; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midshift no result", 32'(seen), 32'd0);
        run_op(4'd2, 32'd1, 32'd1);

        // Illegal code, then a legal op clears the flag
        run_op(4'hF, 32'd3, 32'd4);
        run_op(4'd3, 32'hA5A5_0000, 32'h0000_5A5A);

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            run_op(c, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
